spart_driver: RTL

//  Processor-side initiator for the SPART bus interface. After reset it programs the
//  16-bit baud divisor selected by br_cfg. It then echoes every received byte: poll

---
 rtl/spart_pkg.sv | 40 ++++
 rtl/spart_driver_if.sv | 14 +
 rtl/spart_driver.sv | 102 ++++++++++
 3 files changed

// File: rtl/spart_pkg.sv
// Shared types, baud constants and the divisor lookup for the SPART processor-side driver.
package spart_pkg;

  typedef enum logic [1:0] {
    IO_BUF    = 2'b00,
    IO_STATUS = 2'b01,
    IO_DB_LO  = 2'b10,
    IO_DB_HI  = 2'b11
  } ioaddr_t;

  typedef enum logic [2:0] {
    DB_LO,
    DB_HI,
    POLL,
    READ,
    WAIT_TX,
    WRITE
  } drv_state_t;

  localparam int unsigned BAUD_4800  = 4800;
  localparam int unsigned BAUD_9600  = 9600;
  localparam int unsigned BAUD_19200 = 19200;
  localparam int unsigned BAUD_38400 = 38400;

  // The SPART oversamples by 16 and counts from the divisor down to zero, hence the -1.
  function automatic logic [15:0] divisor_for(input logic [1:0] br_cfg,
                                              input int unsigned clk_freq);
    int unsigned baud;
    int unsigned div;
    case (br_cfg)
      2'b00:   baud = BAUD_4800;
      2'b01:   baud = BAUD_9600;
      2'b10:   baud = BAUD_19200;
      default: baud = BAUD_38400;
    endcase
    div = clk_freq / (16 * baud) - 1;
    return 16'(div);
  endfunction

endpackage

// File: rtl/spart_driver_if.sv
// Control and status sideband between the processor-side driver and the SPART.
interface spart_driver_if;
  import spart_pkg::*;

  logic    iocs;
  logic    iorw;
  ioaddr_t ioaddr;
  logic    rda;
  logic    tbr;

  modport master (output iocs, output iorw, output ioaddr, input rda, input tbr);
  modport slave  (input iocs, input iorw, input ioaddr, output rda, output tbr);

endinterface

// File: rtl/spart_driver.sv
// Programs the SPART baud divisor after reset or a br_cfg change, then echoes
// every received byte back out of the TX buffer.
module spart_driver
  import spart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     br_cfg,
  spart_driver_if.master bus,
  inout  wire  [7:0]     databus
);

  drv_state_t state_q;
  logic [1:0] br_cfg_q;
  logic       cfg_pend_q;
  logic [7:0] rx_byte_q;
  logic       iocs_q;
  logic       iorw_q;
  ioaddr_t    ioaddr_q;
  logic [7:0] wdata_q;

  logic [15:0] divisor;
  logic        cfg_changed;

  assign divisor     = divisor_for(br_cfg_q, CLK_FREQ);
  assign cfg_changed = (br_cfg != br_cfg_q);

  // Outputs are loaded from the current state, so each state's bus cycle shows up
  // one clock after the state is entered; a cfg change seen outside POLL is held pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DB_LO;
      br_cfg_q   <= br_cfg;
      cfg_pend_q <= 1'b0;
      rx_byte_q  <= 8'h00;
      iocs_q     <= 1'b0;
      iorw_q     <= 1'b1;
      ioaddr_q   <= IO_BUF;
      wdata_q    <= 8'h00;
    end else begin
      br_cfg_q <= br_cfg;
      if (cfg_changed) cfg_pend_q <= 1'b1;
      if (iocs_q && iorw_q) rx_byte_q <= databus;

      iocs_q   <= 1'b0;
      iorw_q   <= 1'b1;
      ioaddr_q <= IO_BUF;

      unique case (state_q)
        DB_LO: begin
          iocs_q   <= 1'b1;
          iorw_q   <= 1'b0;
          ioaddr_q <= IO_DB_LO;
          wdata_q  <= divisor[7:0];
          state_q  <= DB_HI;
        end
        DB_HI: begin
          iocs_q   <= 1'b1;
          iorw_q   <= 1'b0;
          ioaddr_q <= IO_DB_HI;
          wdata_q  <= divisor[15:8];
          state_q  <= POLL;
        end
        POLL: begin
          // A waiting byte wins; the pending reprogram is taken on the next visit.
          if (bus.rda) begin
            state_q <= READ;
          end else if (cfg_pend_q || cfg_changed) begin
            cfg_pend_q <= 1'b0;
            state_q    <= DB_LO;
          end
        end
        READ: begin
          iocs_q   <= 1'b1;
          iorw_q   <= 1'b1;
          ioaddr_q <= IO_BUF;
          state_q  <= WAIT_TX;
        end
        WAIT_TX: begin
          if (bus.tbr) state_q <= WRITE;
        end
        WRITE: begin
          iocs_q   <= 1'b1;
          iorw_q   <= 1'b0;
          ioaddr_q <= IO_BUF;
          wdata_q  <= rx_byte_q;
          state_q  <= POLL;
        end
        default: state_q <= DB_LO;
      endcase
    end
  end

  assign bus.iocs   = iocs_q;
  assign bus.iorw   = iorw_q;
  assign bus.ioaddr = ioaddr_q;

  assign databus = (iocs_q && !iorw_q) ? wdata_q : 8'hzz;

endmodule
